// File: rtl/peripheral_tl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : peripheral_tl_pkg                                             |
// | Purpose  : TileLink-UL opcode constants and opcode classification       |
// |            helpers shared by the responder BFM and its response FIFO.   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package peripheral_tl_pkg;

  // Channel A opcodes understood by the responder
  localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET         = 3'd4;

  // Channel D opcodes produced by the responder
  localparam logic [2:0] TL_D_ACK         = 3'd0;
  localparam logic [2:0] TL_D_ACK_DATA    = 3'd1;

  function automatic logic tl_is_put(input logic [2:0] op);
    return (op == TL_A_PUT_FULL) || (op == TL_A_PUT_PARTIAL);
  endfunction

  function automatic logic tl_is_get(input logic [2:0] op);
    return (op == TL_A_GET);
  endfunction

  function automatic logic tl_op_supported(input logic [2:0] op);
    return tl_is_put(op) || tl_is_get(op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_bfm_slave_tl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : peripheral_bfm_slave_tl_if                                    |
// | Purpose  : TileLink-UL A/D channel bundle.                               |
// | Ports    : master modport drives A and d_ready; slave modport drives D   |
// |            and a_ready.                                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface peripheral_bfm_slave_tl_if #(
  parameter int TL_AW    = 32,
  parameter int TL_DW    = 32,
  parameter int TL_SRCW  = 8,
  parameter int TL_SINKW = 1,
  parameter int TL_DBW   = TL_DW >> 3,
  parameter int TL_SZW   = $clog2($clog2(TL_DBW) + 1)
) ();

  // Channel A
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [TL_SZW-1:0]   a_size;
  logic [TL_SRCW-1:0]  a_source;
  logic [TL_AW-1:0]    a_address;
  logic [TL_DBW-1:0]   a_mask;
  logic [TL_DW-1:0]    a_data;
  logic                a_corrupt;
  logic                a_valid;
  logic                a_ready;

  // Channel D
  logic [2:0]          d_opcode;
  logic [2:0]          d_param;
  logic [TL_SZW-1:0]   d_size;
  logic [TL_SRCW-1:0]  d_source;
  logic [TL_SINKW-1:0] d_sink;
  logic                d_denied;
  logic [TL_DW-1:0]    d_data;
  logic                d_corrupt;
  logic                d_valid;
  logic                d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
           a_corrupt, a_valid, d_ready,
    input  a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied,
           d_data, d_corrupt, d_valid
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
           a_corrupt, a_valid, d_ready,
    output a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied,
           d_data, d_corrupt, d_valid
  );

endinterface
`default_nettype wire

// File: rtl/peripheral_tl_rsp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : peripheral_tl_rsp_fifo                                        |
// | Purpose  : DEPTH-entry FIFO holding packed channel-D responses.          |
// | Ports    : clk, reset_n (async, active low); push/push_data;             |
// |            pop/pop_data (head, valid when !empty); full, empty, count.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module peripheral_tl_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNTW = $clog2(DEPTH + 1),
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTRW'(1);
  endfunction

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed through a
  // non-empty head, and every entry is written before it becomes visible.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/peripheral_bfm_slave_tl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : peripheral_bfm_slave_tl                                       |
// | Purpose  : TileLink-UL responder BFM. Decodes channel-A requests against |
// |            an internal word memory and queues AccessAck/AccessAckData    |
// |            responses in a RSP_DEPTH-entry FIFO driven onto channel D.    |
// | Ports    : clk, reset_n (async, active low), tl (slave modport: A in,    |
// |            D out, a_ready out, d_ready in).                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module peripheral_bfm_slave_tl
  import peripheral_tl_pkg::*;
#(
  parameter int              TL_AW     = 32,
  parameter int              TL_DW     = 32,
  parameter int              TL_SRCW   = 8,
  parameter int              TL_SINKW  = 1,
  parameter int              TL_DBW    = TL_DW >> 3,
  parameter int              TL_SZW    = $clog2($clog2(TL_DBW) + 1),
  parameter int              MEM_WORDS = 256,
  parameter logic [TL_AW-1:0] BASE_ADDR = '0,
  parameter int              RSP_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  peripheral_bfm_slave_tl_if.slave  tl
);

  localparam int                LG_DBW    = $clog2(TL_DBW);
  localparam int                IDXW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int                CNTW      = $clog2(RSP_DEPTH + 1);
  localparam logic [TL_AW:0]    MEM_BYTES = (TL_AW + 1)'(MEM_WORDS * TL_DBW);
  localparam logic [TL_SZW-1:0] MAX_SIZE  = TL_SZW'(LG_DBW);

  typedef struct packed {
    logic [2:0]         opcode;
    logic [TL_SZW-1:0]  size;
    logic [TL_SRCW-1:0] source;
    logic               denied;
    logic               corrupt;
    logic [TL_DW-1:0]   data;
  } rsp_t;

  logic [TL_DW-1:0] mem [MEM_WORDS];

  logic             a_fire;
  logic             d_fire;
  logic [TL_AW:0]   offset;
  logic [TL_AW-1:0] align_mask;
  logic             in_range;
  logic             size_ok;
  logic             aligned;
  logic             denied;
  logic             is_get;
  logic             mem_we;
  logic [IDXW-1:0]  index;
  rsp_t             push_rsp;
  rsp_t             head_rsp;
  rsp_t             d_view;
  logic             full;
  logic             empty;
  logic [CNTW-1:0]  count;
  logic             unused_ok;

  // ---------------------------------------------------------------------
  // Request decode (one extra address bit so the window check cannot wrap)
  // ---------------------------------------------------------------------
  assign offset     = {1'b0, tl.a_address} - {1'b0, BASE_ADDR};
  assign in_range   = (tl.a_address >= BASE_ADDR) && (offset < MEM_BYTES);
  assign size_ok    = (tl.a_size <= MAX_SIZE);
  assign align_mask = (TL_AW'(1) << tl.a_size) - TL_AW'(1);
  assign aligned    = ((tl.a_address & align_mask) == '0);
  assign denied     = ~(in_range & size_ok & aligned & tl_op_supported(tl.a_opcode));
  assign is_get     = tl_is_get(tl.a_opcode);
  assign index      = offset[LG_DBW +: IDXW];

  assign a_fire = tl.a_valid & tl.a_ready;
  assign d_fire = tl.d_valid & tl.d_ready;

  // Corrupt write data is acknowledged normally but never lands in memory
  assign mem_we = a_fire & tl_is_put(tl.a_opcode) & ~denied & ~tl.a_corrupt;

  always_comb begin
    push_rsp         = '0;
    push_rsp.opcode  = is_get ? TL_D_ACK_DATA : TL_D_ACK;
    push_rsp.size    = tl.a_size;
    push_rsp.source  = tl.a_source;
    push_rsp.denied  = denied;
    push_rsp.corrupt = denied & is_get;
    // Read happens before this edge's write, which can only be this
    // request's own (non-Get) write, so earlier Puts are always visible.
    if (is_get && !denied) push_rsp.data = mem[index];
  end

  // ---------------------------------------------------------------------
  // Word memory with per-byte write enables; deliberately not reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < TL_DBW; b++) begin
        if (tl.a_mask[b]) mem[index][8*b +: 8] <= tl.a_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response queue
  // ---------------------------------------------------------------------
  peripheral_tl_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (a_fire),
    .push_data (push_rsp),
    .pop       (d_fire),
    .pop_data  (head_rsp),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // a_ready depends only on the registered occupancy
  assign tl.a_ready = ~full;

  // An empty queue presents all-zero D fields
  assign d_view       = empty ? '0 : head_rsp;
  assign tl.d_valid   = ~empty;
  assign tl.d_opcode  = d_view.opcode;
  assign tl.d_param   = '0;
  assign tl.d_size    = d_view.size;
  assign tl.d_source  = d_view.source;
  assign tl.d_sink    = '0;
  assign tl.d_denied  = d_view.denied;
  assign tl.d_data    = d_view.data;
  assign tl.d_corrupt = d_view.corrupt;

  // a_param carries no meaning for this responder
  assign unused_ok = ^{count, tl.a_param};

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bfm_slave_tl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_peripheral_bfm_slave_tl                                    |
// | Purpose  : Directed self-checking bench for the TileLink-UL responder.   |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_peripheral_bfm_slave_tl;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  peripheral_bfm_slave_tl_if tl_if ();

  peripheral_bfm_slave_tl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tl      (tl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the A handshake.
  task automatic send_a(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic corrupt);
    int n;
    tl_if.a_opcode  = op;
    tl_if.a_param   = 3'd0;
    tl_if.a_size    = size;
    tl_if.a_source  = src;
    tl_if.a_address = addr;
    tl_if.a_mask    = mask;
    tl_if.a_data    = data;
    tl_if.a_corrupt = corrupt;
    tl_if.a_valid   = 1'b1;
    n = 0;
    while (!tl_if.a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("a_accept", {63'd0, tl_if.a_ready}, 64'd1);
    if (tl_if.a_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
    tl_if.a_valid = 1'b0;
  endtask

  // Called at a negedge; waits for a response, checks it, and consumes it.
  task automatic recv_d(input string tag, input logic [2:0] op, input logic [1:0] size,
                        input logic [7:0] src, input logic denied, input logic corrupt,
                        input logic [31:0] data);
    int n;
    tl_if.d_ready = 1'b1;
    n = 0;
    while (!tl_if.d_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, {63'd0, tl_if.d_valid}, 64'd1);
    if (tl_if.d_valid) begin
      check({tag, ".opcode"},  {61'd0, tl_if.d_opcode}, {61'd0, op});
      check({tag, ".size"},    {62'd0, tl_if.d_size},   {62'd0, size});
      check({tag, ".source"},  {56'd0, tl_if.d_source}, {56'd0, src});
      check({tag, ".denied"},  {63'd0, tl_if.d_denied}, {63'd0, denied});
      check({tag, ".corrupt"}, {63'd0, tl_if.d_corrupt},{63'd0, corrupt});
      check({tag, ".data"},    {32'd0, tl_if.d_data},   {32'd0, data});
      check({tag, ".param"},   {61'd0, tl_if.d_param},  64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    tl_if.d_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n         = 1'b0;
    tl_if.a_opcode  = '0;
    tl_if.a_param   = '0;
    tl_if.a_size    = '0;
    tl_if.a_source  = '0;
    tl_if.a_address = '0;
    tl_if.a_mask    = '0;
    tl_if.a_data    = '0;
    tl_if.a_corrupt = 1'b0;
    tl_if.a_valid   = 1'b0;
    tl_if.d_ready   = 1'b0;

    // Reset state
    #1;
    check("rst.d_valid", {63'd0, tl_if.d_valid}, 64'd0);
    check("rst.d_data",  {32'd0, tl_if.d_data},  64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel.a_ready", {63'd0, tl_if.a_ready}, 64'd1);
    check("rel.d_valid", {63'd0, tl_if.d_valid}, 64'd0);

    // 1: PutFull then Get
    send_a(3'd0, 2'd2, 8'd3, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    check("t1.latency", {63'd0, tl_if.d_valid}, 64'd1);
    send_a(3'd4, 2'd2, 8'd4, 32'h10, 4'hF, 32'h0, 1'b0);
    recv_d("t1.put", 3'd0, 2'd2, 8'd3, 1'b0, 1'b0, 32'h0);
    recv_d("t1.get", 3'd1, 2'd2, 8'd4, 1'b0, 1'b0, 32'hDEADBEEF);

    // 2: PutPartial on the low half-word
    send_a(3'd1, 2'd2, 8'd5, 32'h10, 4'h3, 32'h00001234, 1'b0);
    recv_d("t2.put", 3'd0, 2'd2, 8'd5, 1'b0, 1'b0, 32'h0);
    send_a(3'd4, 2'd2, 8'd6, 32'h10, 4'hF, 32'h0, 1'b0);
    recv_d("t2.get", 3'd1, 2'd2, 8'd6, 1'b0, 1'b0, 32'hDEAD1234);

    // 3: back-pressure with a full queue, then simultaneous push/pop
    send_a(3'd0, 2'd2, 8'd1, 32'h14, 4'hF, 32'h11223344, 1'b0);
    recv_d("t3.p14", 3'd0, 2'd2, 8'd1, 1'b0, 1'b0, 32'h0);
    send_a(3'd0, 2'd2, 8'd2, 32'h18, 4'hF, 32'h55667788, 1'b0);
    recv_d("t3.p18", 3'd0, 2'd2, 8'd2, 1'b0, 1'b0, 32'h0);
    send_a(3'd4, 2'd2, 8'd7, 32'h10, 4'hF, 32'h0, 1'b0);
    send_a(3'd4, 2'd2, 8'd8, 32'h14, 4'hF, 32'h0, 1'b0);
    check("t3.full_a_ready", {63'd0, tl_if.a_ready}, 64'd0);
    tl_if.a_opcode  = 3'd4;
    tl_if.a_source  = 8'd9;
    tl_if.a_address = 32'h18;
    tl_if.a_valid   = 1'b1;
    repeat (2) @(negedge clk);
    check("t3.held_a_ready", {63'd0, tl_if.a_ready}, 64'd0);
    check("t3.head_src",     {56'd0, tl_if.d_source}, 64'd7);
    check("t3.head_data",    {32'd0, tl_if.d_data}, 64'hDEAD1234);
    tl_if.d_ready = 1'b1;
    @(negedge clk);
    check("t3.ready_back",   {63'd0, tl_if.a_ready}, 64'd1);
    check("t3.src8",         {56'd0, tl_if.d_source}, 64'd8);
    check("t3.data8",        {32'd0, tl_if.d_data}, 64'h11223344);
    @(negedge clk);
    tl_if.a_valid = 1'b0;
    check("t3.src9",         {56'd0, tl_if.d_source}, 64'd9);
    check("t3.data9",        {32'd0, tl_if.d_data}, 64'h55667788);
    check("t3.op9",          {61'd0, tl_if.d_opcode}, 64'd1);
    @(negedge clk);
    check("t3.drained",      {63'd0, tl_if.d_valid}, 64'd0);
    tl_if.d_ready = 1'b0;

    // 4: out-of-range Get, unsupported opcode with memory untouched
    send_a(3'd4, 2'd2, 8'd10, 32'h400, 4'hF, 32'h0, 1'b0);
    recv_d("t4.oor", 3'd1, 2'd2, 8'd10, 1'b1, 1'b1, 32'h0);
    send_a(3'd2, 2'd2, 8'd11, 32'h10, 4'hF, 32'hFFFFFFFF, 1'b0);
    recv_d("t4.op2", 3'd0, 2'd2, 8'd11, 1'b1, 1'b0, 32'h0);
    send_a(3'd4, 2'd2, 8'd12, 32'h10, 4'hF, 32'h0, 1'b0);
    recv_d("t4.mem", 3'd1, 2'd2, 8'd12, 1'b0, 1'b0, 32'hDEAD1234);

    // 5: misaligned and oversize, aligned sub-word Get, corrupt Put
    send_a(3'd4, 2'd1, 8'd13, 32'h11, 4'hF, 32'h0, 1'b0);
    recv_d("t5.misal", 3'd1, 2'd1, 8'd13, 1'b1, 1'b1, 32'h0);
    send_a(3'd4, 2'd3, 8'd14, 32'h0, 4'hF, 32'h0, 1'b0);
    recv_d("t5.size3", 3'd1, 2'd3, 8'd14, 1'b1, 1'b1, 32'h0);
    send_a(3'd4, 2'd1, 8'd15, 32'h12, 4'hC, 32'h0, 1'b0);
    recv_d("t5.half", 3'd1, 2'd1, 8'd15, 1'b0, 1'b0, 32'hDEAD1234);
    send_a(3'd0, 2'd2, 8'd16, 32'h10, 4'hF, 32'h0, 1'b1);
    recv_d("t5.cput", 3'd0, 2'd2, 8'd16, 1'b0, 1'b0, 32'h0);
    send_a(3'd4, 2'd2, 8'd17, 32'h10, 4'hF, 32'h0, 1'b0);
    recv_d("t5.cget", 3'd1, 2'd2, 8'd17, 1'b0, 1'b0, 32'hDEAD1234);

    // 6: asynchronous reset with two queued responses
    send_a(3'd4, 2'd2, 8'd18, 32'h14, 4'hF, 32'h0, 1'b0);
    send_a(3'd4, 2'd2, 8'd19, 32'h18, 4'hF, 32'h0, 1'b0);
    check("t6.queued", {63'd0, tl_if.d_valid}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6.async_d_valid", {63'd0, tl_if.d_valid}, 64'd0);
    check("t6.async_d_src",   {56'd0, tl_if.d_source}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6.a_ready", {63'd0, tl_if.a_ready}, 64'd1);
    tl_if.d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6.no_stale", {63'd0, tl_if.d_valid}, 64'd0);
    end
    tl_if.d_ready = 1'b0;
    send_a(3'd4, 2'd2, 8'd20, 32'h10, 4'hF, 32'h0, 1'b0);
    recv_d("t6.mem_kept", 3'd1, 2'd2, 8'd20, 1'b0, 1'b0, 32'hDEAD1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
